// File: rtl/bv_searcher_param_if.sv
// rtl/bv_searcher_param_if.sv - lookup and rule-update handshake bundle for bv_searcher_param
interface bv_searcher_param_if #(
  parameter int NUM_STRIDE = 5,
  parameter int STRIDE_W   = 8,
  parameter int NUM_RULES  = 64,
  parameter int RULE_ID_W  = 6,
  parameter int BID_W      = 5,
  parameter int KEY_W      = BID_W + NUM_STRIDE * STRIDE_W,
  parameter int UPD_W      = 2 + NUM_STRIDE + NUM_STRIDE * STRIDE_W + RULE_ID_W
);
  logic [KEY_W-1:0]           key;
  logic                       key_valid;
  logic                       key_ready;
  logic                       index_valid;
  logic                       hit;
  logic [BID_W+RULE_ID_W-1:0] index;
  logic                       ruleSet_valid;
  logic [UPD_W-1:0]           ruleSet;
  logic                       ruleSet_ready;
  logic                       result_valid;
  logic [NUM_RULES-1:0]       result;

  modport master (
    output key, key_valid, ruleSet_valid, ruleSet,
    input  key_ready, index_valid, hit, index, ruleSet_ready, result_valid, result
  );

  modport slave (
    input  key, key_valid, ruleSet_valid, ruleSet,
    output key_ready, index_valid, hit, index, ruleSet_ready, result_valid, result
  );
endinterface

// File: rtl/bv_searcher_param.sv
// rtl/bv_searcher_param.sv - strided bit-vector rule lookup with sweep-based add/delete and read
// Optional hit/miss counters are built when BVS_STATS_EN is defined.
module bv_searcher_param #(
  parameter int NUM_STRIDE = 5,
  parameter int STRIDE_W   = 8,
  parameter int NUM_RULES  = 64,
  parameter int RULE_ID_W  = 6,
  parameter int BID_W      = 5,
  parameter int KEY_W      = BID_W + NUM_STRIDE * STRIDE_W,
  parameter int UPD_W      = 2 + NUM_STRIDE + NUM_STRIDE * STRIDE_W + RULE_ID_W
) (
  input  logic                  clk,
  input  logic                  reset,
  bv_searcher_param_if.slave    bus
`ifdef BVS_STATS_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);

  localparam int ENTRIES = 1 << STRIDE_W;
  localparam int VAL_W   = NUM_STRIDE * STRIDE_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_READ
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [STRIDE_W-1:0]    r_cnt;
  logic [STRIDE_W-1:0]    w_cnt_nxt;
  logic                   w_ready;
  logic                   w_sweep_en;
  logic                   w_read_en;
  logic                   w_key_acc;
  logic                   w_upd_acc;
  logic [1:0]             w_op;

  logic [NUM_RULES-1:0]   r_tbl [NUM_STRIDE][ENTRIES];

  logic                   r_upd_add;
  logic [NUM_STRIDE-1:0]  r_upd_mask;
  logic [VAL_W-1:0]       r_upd_val;
  logic [RULE_ID_W-1:0]   r_upd_rid;

  logic                   r_s1_v;
  logic [NUM_RULES-1:0]   r_s1_bv [NUM_STRIDE];
  logic [BID_W-1:0]       r_s1_bid;
  logic                   r_s2_v;
  logic [NUM_RULES-1:0]   r_s2_and;
  logic [BID_W-1:0]       r_s2_bid;
  logic [NUM_RULES-1:0]   w_and;
  logic [RULE_ID_W-1:0]   w_pe_id;

  logic                   r_index_valid;
  logic                   r_hit;
  logic [BID_W+RULE_ID_W-1:0] r_index;

  logic [NUM_RULES-1:0]   w_rd_and;
  logic                   r_result_valid;
  logic [NUM_RULES-1:0]   r_result;

  assign w_op      = bus.ruleSet[UPD_W-1 -: 2];
  assign w_key_acc = bus.key_valid & w_ready;
  assign w_upd_acc = bus.ruleSet_valid & w_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Lookups and updates are only taken in IDLE; reserved op 3 is swallowed there.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready     = 1'b0;
    w_sweep_en  = 1'b0;
    w_read_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (bus.ruleSet_valid) begin
          if (w_op == 2'd1 || w_op == 2'd2) begin
            w_state_nxt = ST_SWEEP;
            w_cnt_nxt   = '0;
          end else if (w_op == 2'd0) begin
            w_state_nxt = ST_READ;
          end
        end
      end
      ST_SWEEP: begin
        w_sweep_en = 1'b1;
        w_cnt_nxt  = r_cnt + 1'b1;
        if (r_cnt == {STRIDE_W{1'b1}}) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_READ: begin
        w_read_en   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_upd_add  <= 1'b0;
      r_upd_mask <= '0;
      r_upd_val  <= '0;
      r_upd_rid  <= '0;
    end else if (w_upd_acc) begin
      r_upd_add  <= (w_op == 2'd1);
      r_upd_mask <= bus.ruleSet[UPD_W-3 -: NUM_STRIDE];
      r_upd_val  <= bus.ruleSet[RULE_ID_W +: VAL_W];
      r_upd_rid  <= bus.ruleSet[RULE_ID_W-1:0];
    end
  end

  // One table row per stride per sweep cycle; a wildcard stride touches every row.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_STRIDE; s++) begin
        for (int e = 0; e < ENTRIES; e++) begin
          r_tbl[s][e] <= '0;
        end
      end
    end else if (w_sweep_en) begin
      for (int s = 0; s < NUM_STRIDE; s++) begin
        if (!r_upd_mask[s] || r_cnt == r_upd_val[s*STRIDE_W +: STRIDE_W]) begin
          r_tbl[s][r_cnt][r_upd_rid] <= r_upd_add;
        end
      end
    end
  end

  always_comb begin
    w_and = '1;
    for (int s = 0; s < NUM_STRIDE; s++) begin
      w_and = w_and & r_s1_bv[s];
    end
  end

  always_comb begin
    w_pe_id = '0;
    for (int r = NUM_RULES - 1; r >= 0; r--) begin
      if (r_s2_and[r]) begin
        w_pe_id = RULE_ID_W'(r);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_v        <= 1'b0;
      r_s2_v        <= 1'b0;
      r_index_valid <= 1'b0;
      r_hit         <= 1'b0;
      r_index       <= '0;
    end else begin
      r_s1_v   <= w_key_acc;
      r_s1_bid <= bus.key[KEY_W-1 -: BID_W];
      for (int s = 0; s < NUM_STRIDE; s++) begin
        r_s1_bv[s] <= r_tbl[s][bus.key[s*STRIDE_W +: STRIDE_W]];
      end
      r_s2_v        <= r_s1_v;
      r_s2_and      <= w_and;
      r_s2_bid      <= r_s1_bid;
      r_index_valid <= r_s2_v;
      if (r_s2_v) begin
        r_hit   <= |r_s2_and;
        r_index <= {r_s2_bid, w_pe_id};
      end
    end
  end

  // Reads ignore the care mask and use the exact row named by each stride value.
  always_comb begin
    w_rd_and = '1;
    for (int s = 0; s < NUM_STRIDE; s++) begin
      w_rd_and = w_rd_and & r_tbl[s][r_upd_val[s*STRIDE_W +: STRIDE_W]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result_valid <= 1'b0;
      r_result       <= '0;
    end else begin
      r_result_valid <= w_read_en;
      if (w_read_en) begin
        r_result <= w_rd_and;
      end
    end
  end

`ifdef BVS_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_index_valid) begin
      if (r_hit) begin
        if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
      end else begin
        if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

  assign bus.key_ready     = w_ready;
  assign bus.ruleSet_ready = w_ready;
  assign bus.index_valid   = r_index_valid;
  assign bus.hit           = r_hit;
  assign bus.index         = r_index;
  assign bus.result_valid  = r_result_valid;
  assign bus.result        = r_result;

endmodule

// File: doc/bv_searcher_param.md
Name: bv_searcher_param

Overview:
Parametrised bit-vector (BV) lookup engine for the programmable parser. It is the successor of the fixed 5×8-bit / 64-rule searcher.
- Key = block id (bid) plus NUM_STRIDE strides of STRIDE_W bits.
- Each stride indexes a 2^STRIDE_W × NUM_RULES BV table. The stride BVs are ANDed and priority-encoded to {bid, rule id}.
- New relative to the predecessor: per-stride wildcard masks on rule add/delete (applied by a sweep FSM), a read opcode, an explicit hit flag, and a key_ready backpressure handshake.

Parameters:
NUM_STRIDE, 5, number of key strides
STRIDE_W, 8, bits per stride; each stride table has 2^STRIDE_W entries
NUM_RULES, 64, rules (BV width); power of two, ≥2
RULE_ID_W, 6, clog2(NUM_RULES)
BID_W, 5, block-id bits carried through the pipeline
KEY_W, BID_W+NUM_STRIDE*STRIDE_W (45), key width
UPD_W, 2+NUM_STRIDE+NUM_STRIDE*STRIDE_W+RULE_ID_W (53), update word width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
key  in  KEY_W  [KEY_W-1 -: BID_W]=bid; stride s = key[s*STRIDE_W +: STRIDE_W]
key_valid  in  1  lookup request
key_ready  out  1  lookup accepted when key_valid&key_ready
index_valid  out  1  lookup result strobe
hit  out  1  ≥1 rule matched (qualified by index_valid)
index  out  BID_W+RULE_ID_W  {bid, lowest matching rule id}; rule id 0 on miss
ruleSet_valid  in  1  update request
ruleSet  in  UPD_W  [UPD_W-1:UPD_W-2] op (0 read, 1 add, 2 del, 3 reserved); next NUM_STRIDE bits = care mask (1 = exact, 0 = wildcard); next NUM_STRIDE*STRIDE_W bits = value; [RULE_ID_W-1:0] = rule id
ruleSet_ready  out  1  update accepted when ruleSet_valid&ruleSet_ready
result_valid  out  1  read response strobe
result  out  NUM_RULES  read response BV

Behaviour:
- Reset (synchronous, high): all table bits 0; FSM to IDLE; sweep counter 0. Outputs: index_valid 0, hit 0, index 0, result_valid 0, result 0, key_ready 1, ruleSet_ready 1. Reset mid-sweep abandons the sweep; the table is fully cleared.
- Lookup pipeline, fixed 3-cycle latency (accept edge → index_valid):
  - S1: register each stride's table entry and the bid.
  - S2: AND all stride BVs.
  - S3: priority-encode the lowest set bit. hit = |AND. index = {bid, id}.
  - One result per accepted key; full throughput; no internal drop.
- FSM states:
  - IDLE: ruleSet_ready=1, key_ready=1.
    - Accept op 1/2 → SWEEP, counter=0.
    - Accept op 0 → READ.
    - Accept op 3 → dropped, stay IDLE.
  - SWEEP: key_ready=0, ruleSet_ready=0, for exactly 2^STRIDE_W cycles.
    - Cycle c, every stride s: if mask[s]==0 or c==value[s], bit rule_id of entry c is set (add) or cleared (del).
    - Counter wraps to 0 after 2^STRIDE_W-1 → IDLE on the next cycle.
  - READ (1 cycle): key_ready=0, ruleSet_ready=0.
    - result = AND over strides of entry value[s]; the mask is ignored for reads.
    - result_valid pulses 1 cycle, 2 cycles after the accept edge. FSM returns to IDLE.
- Simultaneous key and update accepted in IDLE:
  - Both are taken; the lookup reads the pre-update table in S1.
  - Writes start the cycle after acceptance, so lookups already in S2/S3 are unaffected.
- key_valid while key_ready=0: not accepted; upstream holds key. ruleSet_valid while not ready: not accepted.
- Adding an already-set bit or deleting a clear bit is harmless (idempotent).
- Priority: the lowest rule id wins.

Optional Feature:
BVS_STATS_EN.
- Defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0]. Each increments on index_valid with hit=1 or hit=0 respectively, saturating at 0xFFFFFFFF. Both reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then lookup key=0x1F_0102030405 → 3 cycles later index_valid=1, hit=0, index=0x7C0 (bid 0x1F, id 0).
- Add rule 5, mask 5'b11111, value 0x0102030405 → ruleSet_ready low exactly 256 cycles. Then lookup bid 3 same strides → hit=1, index={5'd3,6'd5}=0x0C5. Stride 0 changed to 0x06 → hit=0.
- Add rule 9 (all-wildcard), then rule 2 exact 0xAABBCCDDEE → key with those strides gives id 2; any other key gives id 9. Delete rule 2 → same key gives id 9.
- Lookup accepted in the same cycle as an add for its exact value → that lookup misses. The next lookup after the sweep hits. key_ready=0 throughout the sweep; a held key is accepted on the first IDLE cycle.
- Read op value 0x0102030405 after the adds above → result_valid 2 cycles after accept, result=64'h0000_0000_0000_0220 (bits 5 and 9). Op 3 → no response, ruleSet_ready stays 1.
- Reset asserted at sweep cycle 100 → next cycle ruleSet_ready=1, any lookup misses. With BVS_STATS_EN: 3 hits + 2 misses → hit_cnt=3, miss_cnt=2.
